// File: rtl/scfifo_valid_model.sv
// Single-clock FIFO model that stores a valid (taint) bit beside each payload word.
// Supports normal and show-ahead read modes and sticky overflow/underflow flags.
module scfifo_valid_model #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTHU    = 4,
  parameter int unsigned SHOWAHEAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data,
  input  logic              data_valid,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [WIDTH-1:0]  q,
  output logic              valid_q,
  output logic              valid_q_q,
  output logic              empty,
  output logic              full,
  output logic [WIDTHU:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = WIDTHU + 1;

  logic [WIDTH-1:0]  mem_data  [DEPTH];
  logic              mem_valid [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WIDTHU-1:0] wr_idx;
  logic [WIDTHU-1:0] rd_idx;
  logic              wr_acc;
  logic              rd_acc;

  // Occupancy and handshake acceptance derived from the pointer pair
  always_comb begin
    wr_idx = wr_ptr[WIDTHU-1:0];
    rd_idx = rd_ptr[WIDTHU-1:0];
    usedw  = wr_ptr - rd_ptr;
    empty  = (usedw == PTR_W'(0));
    full   = (usedw == PTR_W'(DEPTH));
    wr_acc = wrreq & ~full;
    rd_acc = rdreq & ~empty;
  end

  // Storage write; contents survive reset but become unreachable
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_data[wr_idx]  <= data;
      mem_valid[wr_idx] <= data_valid;
    end
  end

  // Pointer advance and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(wr_acc);
      rd_ptr    <= rd_ptr + PTR_W'(rd_acc);
      overflow  <= overflow | (wrreq & full);
      underflow <= underflow | (rdreq & empty);
    end
  end

  generate
    if (SHOWAHEAD != 0) begin : g_showahead
      // Head entry is presented directly; qualified by occupancy
      always_comb begin
        q       = mem_data[rd_idx];
        valid_q = mem_valid[rd_idx] & ~empty;
      end
    end else begin : g_normal
      logic [WIDTH-1:0] q_reg;
      logic             valid_reg;

      // Read data registered one cycle after an accepted read; valid pulses once
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_reg     <= '0;
          valid_reg <= 1'b0;
        end else begin
          if (rd_acc) begin
            q_reg <= mem_data[rd_idx];
          end
          valid_reg <= rd_acc & mem_valid[rd_idx];
        end
      end

      always_comb begin
        q       = q_reg;
        valid_q = valid_reg;
      end
    end
  endgenerate

  // One-cycle delayed copy of the qualified valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q_q <= 1'b0;
    end else begin
      valid_q_q <= valid_q;
    end
  end

endmodule

// File: tb/tb_scfifo_valid_model.sv
// Bench for scfifo_valid_model: normal and show-ahead instances driven in parallel,
// compared every cycle against a queue-based reference model.
module tb_scfifo_valid_model;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned WU = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data;
  logic         data_valid;
  logic         wrreq;
  logic         rdreq;

  logic [W-1:0] q0, q1;
  logic         vq0, vq1, vqq0, vqq1, empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;
  logic [WU:0]  usedw0, usedw1;

  always #5 clk = ~clk;

  scfifo_valid_model #(.WIDTH(W), .DEPTH(D), .WIDTHU(WU), .SHOWAHEAD(0)) u_norm (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .wrreq(wrreq), .rdreq(rdreq), .q(q0), .valid_q(vq0), .valid_q_q(vqq0),
    .empty(empty0), .full(full0), .usedw(usedw0), .overflow(ovf0), .underflow(unf0)
  );

  scfifo_valid_model #(.WIDTH(W), .DEPTH(D), .WIDTHU(WU), .SHOWAHEAD(1)) u_sa (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .wrreq(wrreq), .rdreq(rdreq), .q(q1), .valid_q(vq1), .valid_q_q(vqq1),
    .empty(empty1), .full(full1), .usedw(usedw1), .overflow(ovf1), .underflow(unf1)
  );

  // Reference model state: queue of {valid, payload}
  logic [W:0]   mq[$];
  logic [W-1:0] exp_q0;
  logic         exp_vq0, exp_vqq0, exp_vqq1, exp_ovf, exp_unf;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("norm.usedw", 32'(usedw0), 32'(n));
    chk("norm.empty", 32'(empty0), 32'(n == 0));
    chk("norm.full", 32'(full0), 32'(n == D));
    chk("norm.overflow", 32'(ovf0), 32'(exp_ovf));
    chk("norm.underflow", 32'(unf0), 32'(exp_unf));
    chk("norm.q", 32'(q0), 32'(exp_q0));
    chk("norm.valid_q", 32'(vq0), 32'(exp_vq0));
    chk("norm.valid_q_q", 32'(vqq0), 32'(exp_vqq0));
    chk("sa.usedw", 32'(usedw1), 32'(n));
    chk("sa.empty", 32'(empty1), 32'(n == 0));
    chk("sa.full", 32'(full1), 32'(n == D));
    chk("sa.overflow", 32'(ovf1), 32'(exp_ovf));
    chk("sa.underflow", 32'(unf1), 32'(exp_unf));
    chk("sa.valid_q", 32'(vq1), (n != 0) ? 32'(mq[0][W]) : 32'd0);
    chk("sa.valid_q_q", 32'(vqq1), 32'(exp_vqq1));
    if (n != 0) chk("sa.q", 32'(q1), 32'(mq[0][W-1:0]));
  endtask

  // Drive one cycle, advance the model across the edge, then check
  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic v, input logic rd);
    logic [W:0] head;
    logic       sa_vq_old;
    int         n;
    rst_n = r; wrreq = w; data = d; data_valid = v; rdreq = rd;
    @(posedge clk);
    n = mq.size();
    sa_vq_old = (n != 0) ? mq[0][W] : 1'b0;
    if (!r) begin
      mq.delete();
      exp_q0 = '0; exp_vq0 = 1'b0; exp_vqq0 = 1'b0; exp_vqq1 = 1'b0;
      exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      exp_vqq0 = exp_vq0;
      exp_vqq1 = sa_vq_old;
      if (w && n == D) exp_ovf = 1'b1;
      if (rd && n == 0) exp_unf = 1'b1;
      if (rd && n != 0) begin
        head = mq.pop_front();
        exp_q0 = head[W-1:0];
        exp_vq0 = head[W];
      end else begin
        exp_vq0 = 1'b0;
      end
      if (w && n != D) mq.push_back({v, d});
    end
    #1;
    check_all();
  endtask

  initial begin
    int bias;
    rst_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0; data_valid = 1'b0;
    exp_q0 = '0; exp_vq0 = 1'b0; exp_vqq0 = 1'b0; exp_vqq1 = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0;

    // Basic write then two reads, valid bit travels with data
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'hA5, 1, 0);
    step(1, 1, 8'h3C, 0, 0);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 1);
    chk("t1.q_last", 32'(q0), 32'h3C);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // Fill, then write while full with rdreq high: write dropped, overflow sticky
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h10 + i), 1'(i), 0);
    step(1, 1, 8'hEE, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 1);
    chk("t2.overflow_sticky", 32'(ovf0), 32'd1);

    // Underflow from read on empty right after reset
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 1);
    chk("t3.q_zero", 32'(q0), 32'h00);

    // Steady streaming at usedw=2, pointers wrap several times
    step(1, 1, 8'h21, 1, 0);
    step(1, 1, 8'h22, 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, 1, 8'($urandom), 1'($urandom), 1);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 1);

    // Show-ahead: written entry visible next cycle without a read
    step(0, 0, 8'h00, 0, 0);
    step(1, 1, 8'h77, 1, 0);
    chk("t5.sa_q", 32'(q1), 32'h77);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 1);

    // Reset at usedw=3 with a pending read discards everything
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h40 + i), 1, 0);
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h99, 1, 0);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 0);

    // Randomized traffic with shifting write/read bias and rare resets
    for (int blk = 0; blk < 8; blk++) begin
      bias = int'($urandom_range(0, 4));
      for (int i = 0; i < 50; i++) begin
        step(1'($urandom_range(0, 59) != 0),
             1'(int'($urandom_range(0, 3)) < bias),
             8'($urandom), 1'($urandom),
             1'(int'($urandom_range(0, 3)) >= bias - 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
